// File: rtl/pc_npc_sequencer.sv
// ============================================================================
//  Module   : pc_npc_sequencer
//  Purpose  : PC/NPC fetch sequencer with delayed branches, annulled-slot
//             squash and unconditional jumps.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_npc_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_valid,
    input  logic        branch_taken,
    input  logic        annul,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] pc,
    output logic [31:0] npc,
    output logic        le_pc,
    output logic        le_npc,
    output logic        delay_slot,
    output logic        nop_insert,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DELAY   = 2'd1,
        ST_SQUASH  = 2'd2,
        ST_UNUSED  = 2'd3
    } state_t;

    localparam logic [31:0] c_PC_RESET  = 32'h0000_0000;
    localparam logic [31:0] c_NPC_RESET = 32'h0000_0004;
    localparam logic [31:0] c_INC       = 32'h0000_0004;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_pc;
    logic [31:0] r_npc;
    logic [31:0] w_next_pc;
    logic [31:0] w_next_npc;
    logic        w_advance;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc    <= c_PC_RESET;
            r_npc   <= c_NPC_RESET;
            r_state <= ST_RUN;
        end else begin
            r_pc    <= w_next_pc;
            r_npc   <= w_next_npc;
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_pc    = r_pc;
        w_next_npc   = r_npc;
        w_next_state = r_state;
        w_advance    = 1'b0;
        if (!stall) begin
            w_advance    = 1'b1;
            w_next_pc    = r_npc;
            w_next_npc   = r_npc + c_INC;
            w_next_state = ST_RUN;
            case (r_state)
                ST_DELAY, ST_SQUASH: begin
                    // Slot cycles never redirect; they always fall through to RUN.
                end
                default: begin
                    // RUN, and the unused encoding recovering with RUN behaviour.
                    if (jump) begin
                        w_next_npc   = {jump_target[31:2], 2'b00};
                        w_next_state = ST_DELAY;
                    end else if (branch_valid && branch_taken) begin
                        w_next_npc   = {branch_target[31:2], 2'b00};
                        w_next_state = ST_DELAY;
                    end else if (branch_valid && annul) begin
                        w_next_state = ST_SQUASH;
                    end
                end
            endcase
        end
    end

    assign pc         = r_pc;
    assign npc        = r_npc;
    assign state      = r_state;
    assign le_pc      = w_advance && !reset;
    assign le_npc     = w_advance && !reset;
    // Only reset qualifies the slot flags; stall and redirects never reach them.
    assign delay_slot = (r_state == ST_DELAY)  && !reset;
    assign nop_insert = (r_state == ST_SQUASH) && !reset;

endmodule

`default_nettype wire

// File: tb/tb_pc_npc_sequencer.sv
// Directed bench for pc_npc_sequencer: linear steps with hand-computed expectations.
`default_nettype none

module tb_pc_npc_sequencer;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_valid;
    logic        branch_taken;
    logic        annul;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        le_pc;
    logic        le_npc;
    logic        delay_slot;
    logic        nop_insert;
    logic [1:0]  state;

    int vectors;
    int miscompares;

    pc_npc_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_valid  (branch_valid),
        .branch_taken  (branch_taken),
        .annul         (annul),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .pc            (pc),
        .npc           (npc),
        .le_pc         (le_pc),
        .le_npc        (le_npc),
        .delay_slot    (delay_slot),
        .nop_insert    (nop_insert),
        .state         (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Full registered snapshot plus the slot flags.
    task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_npc,
                           input logic [1:0] e_st, input logic e_ds, input logic e_nop);
        chk({tag, ".pc"},    pc,         e_pc);
        chk({tag, ".npc"},   npc,        e_npc);
        chk({tag, ".state"}, {30'd0, state},      {30'd0, e_st});
        chk({tag, ".ds"},    {31'd0, delay_slot}, {31'd0, e_ds});
        chk({tag, ".nop"},   {31'd0, nop_insert}, {31'd0, e_nop});
    endtask

    task automatic chk_le(input string tag, input logic e);
        chk({tag, ".le_pc"},  {31'd0, le_pc},  {31'd0, e});
        chk({tag, ".le_npc"}, {31'd0, le_npc}, {31'd0, e});
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        reset         = 1'b1;
        stall         = 1'b0;
        branch_valid  = 1'b0;
        branch_taken  = 1'b0;
        annul         = 1'b0;
        branch_target = 32'h0;
        jump          = 1'b0;
        jump_target   = 32'h0;

        // Reset, with a stall and a jump present that must be overridden
        stall = 1'b1; jump = 1'b1; jump_target = 32'h0000_0880;
        step; step;
        chk_all("reset", 32'h0, 32'h4, 2'd0, 1'b0, 1'b0);
        chk_le("reset", 1'b0);
        stall = 1'b0; jump = 1'b0;
        reset = 1'b0;
        #1;
        chk_le("run_idle", 1'b1);

        // Free-running sequence
        step; chk_all("seq1", 32'h4, 32'h8, 2'd0, 1'b0, 1'b0);
        step; chk_all("seq2", 32'h8, 32'hC, 2'd0, 1'b0, 1'b0);
        step; chk_all("seq3", 32'hC, 32'h10, 2'd0, 1'b0, 1'b0);
        step; chk_all("seq4", 32'h10, 32'h14, 2'd0, 1'b0, 1'b0);

        // Taken branch, misaligned target forced to 0x100
        branch_valid = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0103; annul = 1'b1;
        step; chk_all("br_taken", 32'h14, 32'h100, 2'd1, 1'b1, 1'b0);
        branch_valid = 1'b0; branch_taken = 1'b0; annul = 1'b0;
        step; chk_all("br_after", 32'h100, 32'h104, 2'd0, 1'b0, 1'b0);

        // Jump to 0x20 to set up the annul case
        jump = 1'b1; jump_target = 32'h0000_0020;
        step; chk_all("jmp20", 32'h104, 32'h20, 2'd1, 1'b1, 1'b0);
        jump = 1'b0;
        step; chk_all("jmp20_slot", 32'h20, 32'h24, 2'd0, 1'b0, 1'b0);

        // Not-taken annulled branch squashes the slot; jump during SQUASH ignored
        branch_valid = 1'b1; branch_taken = 1'b0; annul = 1'b1; branch_target = 32'h0000_0700;
        step; chk_all("squash", 32'h24, 32'h28, 2'd2, 1'b0, 1'b1);
        branch_valid = 1'b0; annul = 1'b0;
        jump = 1'b1; jump_target = 32'h0000_0400;
        step; chk_all("squash_after", 32'h28, 32'h2C, 2'd0, 1'b0, 1'b0);
        jump = 1'b0;

        // Stall with jump and branch both pending: frozen, then jump wins
        jump = 1'b1; jump_target = 32'h0000_0200;
        branch_valid = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0300;
        stall = 1'b1;
        #1; chk_le("stall0", 1'b0);
        step; chk_all("stall1", 32'h28, 32'h2C, 2'd0, 1'b0, 1'b0); chk_le("stall1", 1'b0);
        step; chk_all("stall2", 32'h28, 32'h2C, 2'd0, 1'b0, 1'b0); chk_le("stall2", 1'b0);
        stall = 1'b0;
        #1; chk_le("unstall", 1'b1);
        step; chk_all("jmp_wins", 32'h2C, 32'h200, 2'd1, 1'b1, 1'b0);
        jump = 1'b0; branch_valid = 1'b0; branch_taken = 1'b0;
        step; chk_all("jmp_slot", 32'h200, 32'h204, 2'd0, 1'b0, 1'b0);

        // Reset while in DELAY abandons the slot
        jump = 1'b1; jump_target = 32'h0000_0500;
        step; chk_all("to_delay", 32'h204, 32'h500, 2'd1, 1'b1, 1'b0);
        jump = 1'b0;
        reset = 1'b1;
        #1; chk("rst_in_delay.ds", {31'd0, delay_slot}, 32'd0); chk_le("rst_in_delay", 1'b0);
        step; chk_all("rst_delay", 32'h0, 32'h4, 2'd0, 1'b0, 1'b0);
        reset = 1'b0;

        // Wrap-around: misaligned jump target 0xFFFFFFFE loads as 0xFFFFFFFC
        jump = 1'b1; jump_target = 32'hFFFF_FFFE;
        step; chk_all("wrap_jmp", 32'h4, 32'hFFFF_FFFC, 2'd1, 1'b1, 1'b0);
        jump = 1'b0;
        step; chk_all("wrap1", 32'hFFFF_FFFC, 32'h0, 2'd0, 1'b0, 1'b0);
        step; chk_all("wrap2", 32'h0, 32'h4, 2'd0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
